counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRI, default 0: 0 = round-robin between A and B; 1 = A always wins contention.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_a, input, 1 bit: requester A wants one counter operation; level, held until gnt_a.
REQ-005 The block SHALL have port op_a, input, 1 bit: A operation, 0 = increment, 1 = load; stable while req_a high.
REQ-006 The block SHALL have port din_a, input, 3 bits: A load value; stable while req_a high.
REQ-007 The block SHALL have ports req_b, op_b and din_b, inputs, 1/1/3 bits: requester B, same meaning as the A ports.
REQ-008 The block SHALL have ports gnt_a and gnt_b, outputs, 1 bit each: one-cycle pulse when that requester's operation issues.
REQ-009 The block SHALL have port cnt_ld, output, 1 bit: load strobe to the three-bit counter.
REQ-010 The block SHALL have port cnt_inc, output, 1 bit: increment strobe to the counter.
REQ-011 The block SHALL have port cnt_data, output, 3 bits: load value to the counter.
REQ-012 The block SHALL have port cnt_q, input, 3 bits: current counter output.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse when an increment is blocked at saturation.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE, SETTLE; IDLE→ISSUE when req_a|req_b at the edge; ISSUE→SETTLE always; SETTLE→IDLE always.
REQ-016 On the IDLE→ISSUE edge the block SHALL select the winner, register its op and din, and record it as last_grant.
REQ-017 Contention with FIXED_PRI=0 SHALL go to the requester not equal to last_grant; with FIXED_PRI=1, A SHALL always win.
REQ-018 In ISSUE the block SHALL pulse the winner's gnt; it SHALL also pulse cnt_ld (cnt_data = registered din) for a load, or cnt_inc for an increment.
REQ-019 cnt_ld and cnt_inc SHALL never be high together, and SHALL be low outside ISSUE.
REQ-020 cnt_data SHALL be 3'b000 whenever cnt_ld is low.
REQ-021 Latency SHALL be: req sampled at edge N → gnt and strobe during cycle N+1 → counter updated by cycle N+2 (SETTLE) → IDLE in cycle N+3.
REQ-022 Peak throughput SHALL be one operation every 3 cycles.
REQ-023 A requester still holding req in IDLE after its gnt SHALL be treated as a new request.
REQ-024 The loser of contention SHALL be granted in the next IDLE→ISSUE decision when FIXED_PRI=0, so it waits at most 3 cycles.
REQ-025 Requests arriving in ISSUE or SETTLE SHALL be ignored until IDLE, with no loss while req is held.
REQ-026 The counter SHALL be written only during ISSUE.

Reset
REQ-027 A reset sampled low at any edge SHALL force IDLE, abandoning any in-flight operation; no strobe SHALL issue in the next cycle.
REQ-028 Reset SHALL clear gnt_a, gnt_b, cnt_ld, cnt_inc, busy and err to 0, and cnt_data and the registered op/din to 0.
REQ-029 Reset SHALL set last_grant to B, so A wins the first contention.

Configuration
REQ-030 With macro COUNTER_ARB_SATGUARD_EN defined: in ISSUE, if the op is increment and cnt_q == 3'h7, cnt_inc SHALL stay low, gnt SHALL still pulse, and err SHALL pulse in the same cycle.
REQ-031 Without COUNTER_ARB_SATGUARD_EN: err SHALL be tied 0 and an increment at cnt_q == 3'h7 SHALL be forwarded; counter wrap is the counter's behaviour.

Verification
REQ-032 Bench: rst=0 for 2 cycles, then 1 → all outputs 0, busy=0.
REQ-033 Bench: req_a=1, op_a=1, din_a=5, no B → gnt_a and cnt_ld=1, cnt_data=5 one cycle after sampling; cnt_q=5 in SETTLE; busy high 2 cycles.
REQ-034 Bench: req_a and req_b both held, both increment, FIXED_PRI=0 → grants A,B,A,B at 3-cycle spacing; cnt_q advances by 1 per grant.
REQ-035 Bench: same stimulus with FIXED_PRI=1 → gnt_a only while req_a held; B granted on the first decision after req_a drops.
REQ-036 Bench: cnt_q=7, B increment, macro defined → gnt_b=1, cnt_inc=0, err=1, cnt_q stays 7; macro undefined → cnt_inc=1, err=0.
REQ-037 Bench: rst low during ISSUE of an A load → no strobe next cycle, IDLE; after release, contention grants A first.

Source files
------------

// File: rtl/counter_arbiter.sv
// Two-requester arbiter feeding a 3-bit counter: IDLE -> ISSUE -> SETTLE, one op per 3 cycles.
// Define COUNTER_ARB_SATGUARD_EN to block increments at saturation and pulse err instead.
module counter_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       op_a,
    input  logic [2:0] din_a,
    input  logic       req_b,
    input  logic       op_b,
    input  logic [2:0] din_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       cnt_ld,
    output logic       cnt_inc,
    output logic [2:0] cnt_data,
    input  logic [2:0] cnt_q,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t     state;
    logic       last_grant;  // 1 = B was granted last
    logic [2:0] din_r;
    logic       pick_b;
    logic       sel_op;
    logic [2:0] sel_din;

    // B wins if alone, or on contention in round-robin mode when A went last
    always_comb begin
        pick_b  = req_b & (~req_a | (~FIXED_PRI & ~last_grant));
        sel_op  = pick_b ? op_b : op_a;
        sel_din = pick_b ? din_b : din_a;
    end

`ifdef COUNTER_ARB_SATGUARD_EN
    logic sat;
    // The counter only moves in ISSUE, so cnt_q at the decision edge is its ISSUE value
    assign sat = (cnt_q == 3'h7);
`else
    logic unused_cnt_q;
    assign unused_cnt_q = ^cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            din_r      <= 3'b000;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            cnt_ld     <= 1'b0;
            cnt_inc    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            cnt_ld  <= 1'b0;
            cnt_inc <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        last_grant <= pick_b;
                        din_r      <= sel_op ? sel_din : 3'b000;
                        gnt_a      <= ~pick_b;
                        gnt_b      <= pick_b;
                        if (sel_op) begin
                            cnt_ld <= 1'b1;
                        end else begin
`ifdef COUNTER_ARB_SATGUARD_EN
                            cnt_inc <= ~sat;
                            err     <= sat;
`else
                            cnt_inc <= 1'b1;
`endif
                        end
                    end
                end
                ISSUE: state <= SETTLE;
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Load data is visible only alongside its strobe
    assign cnt_data = cnt_ld ? din_r : 3'b000;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: round-robin and fixed-priority instances, each driving a model counter.
// Expected grants are queued as requests are posted and checked when a grant pulse appears.
module tb_counter_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_a, op_a, req_b, op_b, gnt_a, gnt_b, cnt_ld, cnt_inc, busy, err;
    logic [2:0] din_a [2];
    logic [2:0] din_b [2];
    logic [2:0] cnt_data [2];
    logic [2:0] cnt_q [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        counter_arbiter #(.FIXED_PRI(g == 1)) u_dut (
            .clk(clk), .rst(rst),
            .req_a(req_a[g]), .op_a(op_a[g]), .din_a(din_a[g]),
            .req_b(req_b[g]), .op_b(op_b[g]), .din_b(din_b[g]),
            .gnt_a(gnt_a[g]), .gnt_b(gnt_b[g]),
            .cnt_ld(cnt_ld[g]), .cnt_inc(cnt_inc[g]), .cnt_data(cnt_data[g]),
            .cnt_q(cnt_q[g]), .busy(busy[g]), .err(err[g])
        );
    end

    // Counter models driven by the strobes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst)            cnt_q[i] <= 3'd0;
            else if (cnt_ld[i])  cnt_q[i] <= cnt_data[i];
            else if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + 3'd1;
        end
    end

    typedef struct {
        logic       b;
        logic       ld;
        logic       inc;
        logic [2:0] data;
        logic       err;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   gq0[$];
    int   tests = 0, fails = 0, cyc = 0, busy_n = 0;
    int   rem_a [2];
    int   rem_b [2];
    logic pend_v [2];
    logic [2:0] pend_cnt [2];
    int   gcyc [2];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(logic b, logic ld, logic inc, logic [2:0] data, logic e, logic [2:0] cnt);
        exp_t x;
        x.b = b; x.ld = ld; x.inc = inc; x.data = data; x.err = e; x.cnt = cnt;
        return x;
    endfunction

    task automatic push(input int i, input exp_t e);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic rq(input int i, input bit isb, input bit op, input logic [2:0] din, input int n);
        if (isb) begin
            req_b[i] = 1'b1; op_b[i] = op; din_b[i] = din; rem_b[i] = n;
        end else begin
            req_a[i] = 1'b1; op_a[i] = op; din_a[i] = din; rem_a[i] = n;
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        int   sz;
        if (pend_v[i]) begin
            chk("cnt_q", {5'd0, cnt_q[i]}, {5'd0, pend_cnt[i]});
            pend_v[i] = 1'b0;
        end
        chk("ld_inc_excl", {7'd0, cnt_ld[i] & cnt_inc[i]}, 8'd0);
        if (!cnt_ld[i]) chk("data_zero", {5'd0, cnt_data[i]}, 8'd0);
        if (gnt_a[i] | gnt_b[i]) begin
            gcyc[i] = cyc;
            if (i == 0) gq0.push_back(cyc);
            sz = (i == 0) ? sb0.size() : sb1.size();
            if (sz == 0) begin
                chk("unexp_gnt", {6'd0, gnt_a[i], gnt_b[i]}, 8'd0);
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk("gnt_who", {6'd0, gnt_a[i], gnt_b[i]}, e.b ? 8'd1 : 8'd2);
                chk("gnt_ld", {7'd0, cnt_ld[i]}, {7'd0, e.ld});
                chk("gnt_inc", {7'd0, cnt_inc[i]}, {7'd0, e.inc});
                chk("gnt_data", {5'd0, cnt_data[i]}, {5'd0, e.data});
                chk("gnt_err", {7'd0, err[i]}, {7'd0, e.err});
                pend_cnt[i] = e.cnt;
                pend_v[i]   = 1'b1;
            end
        end else begin
            chk("idle_strobe", {5'd0, cnt_ld[i], cnt_inc[i], err[i]}, 8'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (busy[0]) busy_n++;
        for (int i = 0; i < 2; i++) mon(i);
        for (int i = 0; i < 2; i++) begin
            if (gnt_a[i] && rem_a[i] > 0) begin
                rem_a[i]--;
                if (rem_a[i] == 0) req_a[i] = 1'b0;
            end
            if (gnt_b[i] && rem_b[i] > 0) begin
                rem_b[i]--;
                if (rem_b[i] == 0) req_b[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (n < maxc && (sb0.size() != 0 || sb1.size() != 0 || busy != 2'b00 ||
               pend_v[0] || pend_v[1] || rem_a[0] + rem_a[1] + rem_b[0] + rem_b[1] != 0)) begin
            step();
            n++;
        end
        chk("drain_left", 8'(sb0.size() + sb1.size() + rem_a[0] + rem_a[1] + rem_b[0] + rem_b[1]), 8'd0);
    endtask

    initial begin
        int c0;
        req_a = '0; op_a = '0; req_b = '0; op_b = '0;
        for (int i = 0; i < 2; i++) begin
            din_a[i] = '0; din_b[i] = '0; rem_a[i] = 0; rem_b[i] = 0;
            pend_v[i] = 1'b0; pend_cnt[i] = '0; gcyc[i] = 0;
        end

        // Reset state
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("rst_gnt", {4'd0, gnt_a, gnt_b}, 8'd0);
        chk("rst_strobe", {2'd0, cnt_ld, cnt_inc, err}, 8'd0);
        chk("rst_busy", {6'd0, busy}, 8'd0);
        chk("rst_data", {2'd0, cnt_data[1], cnt_data[0]}, 8'd0);

        // Single A load of 5: grant one cycle after sampling, busy for two cycles
        push(0, mk(1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd5));
        rq(0, 1'b0, 1'b1, 3'd5, 1);
        c0 = cyc; busy_n = 0;
        drain(20);
        chk("lat_gnt", 8'(gcyc[0] - c0), 8'd1);
        chk("busy_cycles", 8'(busy_n), 8'd2);

        // Round-robin contention from reset: A,B,A,B at 3-cycle spacing
        rst = 1'b0; step(); rst = 1'b1;
        gq0.delete();
        push(0, mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1));
        push(0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2));
        push(0, mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3));
        push(0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd4));
        rq(0, 1'b0, 1'b0, 3'd0, 2);
        rq(0, 1'b1, 1'b0, 3'd0, 2);
        drain(40);
        chk("rr_grants", 8'(gq0.size()), 8'd4);
        for (int k = 0; k + 1 < gq0.size(); k++) chk("rr_spacing", 8'(gq0[k+1] - gq0[k]), 8'd3);

        // Fixed priority: A held for two ops starves B until it drops
        push(1, mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1));
        push(1, mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2));
        push(1, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd3));
        rq(1, 1'b0, 1'b0, 3'd0, 2);
        rq(1, 1'b1, 1'b0, 3'd0, 1);
        drain(40);

        // Increment at saturation
        push(0, mk(1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 3'd7));
        rq(0, 1'b0, 1'b1, 3'd7, 1);
        drain(20);
`ifdef COUNTER_ARB_SATGUARD_EN
        push(0, mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7));
`else
        push(0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0));
`endif
        rq(0, 1'b1, 1'b0, 3'd0, 1);
        drain(20);

        // Reset during ISSUE of an A load: the bench counter clears on the same edge
        push(0, mk(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 3'd0));
        rq(0, 1'b0, 1'b1, 3'd3, 1);
        for (int k = 0; k < 10 && !gnt_a[0]; k++) step();
        chk("issue_seen", {7'd0, gnt_a[0]}, 8'd1);
        rst = 1'b0;
        step();
        chk("abort_strobe", {5'd0, cnt_ld[0], cnt_inc[0], gnt_a[0]}, 8'd0);
        chk("abort_busy", {7'd0, busy[0]}, 8'd0);
        rst = 1'b1;
        push(0, mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd1));
        push(0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd2));
        rq(0, 1'b0, 1'b0, 3'd0, 1);
        rq(0, 1'b1, 1'b0, 3'd0, 1);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
